stage_sched: RTL

STAGE_SCHED -- requirements
Module: stage_sched

---
 rtl/stage_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/stage_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stage_pkg.sv
// Shared types and constants for the stage scheduler.
package stage_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 17;
  localparam int KEY_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Expand a requester index into its one-hot ready strobe.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester wins outright,
// a tie goes to the requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Pick the winner from the request pattern and the last-granted index.
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_sched.sv
// Stage scheduler: arbitrates two requesters, issues one operation at a
// time to an external stage, waits for completion or timeout, and returns
// the result on a valid/ready response channel.
module stage_sched
  import stage_pkg::*;
#(
  parameter int               TIMEOUT_CYC = 15,
  parameter logic [KEY_W-1:0] KEY_RST     = 5'b00000
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  input  logic                key_wr,
  input  logic [KEY_W-1:0]    key_in,
  output logic                stg_start,
  output logic [DATA_W-1:0]   stg_data,
  output logic [KEY_W-1:0]    stg_key,
  input  logic                stg_done,
  input  logic [RES_W-1:0]    stg_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [RES_W-1:0]    rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  // WAIT lasts exactly TIMEOUT_CYC cycles: the timer is 0 in the first one.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e             state_r, state_s;
  logic [KEY_W-1:0]   key_r, key_snap_r;
  logic [DATA_W-1:0]  data_r;
  logic               id_r, last_r;
  logic [7:0]         timer_r;
  logic [RES_W-1:0]   rsp_data_r;
  logic               rsp_err_r;
  logic               grant_s, gvalid_s;
  logic               accept_s, done_s, tmo_s, release_s;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_r),
    .grant (grant_s),
    .valid (gvalid_s)
  );

  // State register.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus single-cycle event strobes and the ready strobe.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    tmo_s     = 1'b0;
    release_s = 1'b0;
    req_ready = 2'b00;
    case (state_r)
      IDLE: begin
        // Held reset must not leak a ready strobe through the comb path.
        if (gvalid_s && !rst) begin
          state_s   = ISSUE;
          accept_s  = 1'b1;
          req_ready = onehot2(grant_s);
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        // Completion takes precedence over a coinciding timeout.
        if (stg_done) begin
          state_s = RESP;
          done_s  = 1'b1;
        end else if (timer_r == TMO_LAST) begin
          state_s = RESP;
          tmo_s   = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s   = IDLE;
          release_s = 1'b1;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Key register: writable in any state; operations use their own snapshot.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      key_r <= KEY_RST;
    end else if (key_wr) begin
      key_r <= key_in;
    end
  end

  // Capture the granted word, key snapshot and requester id on accept.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      data_r     <= '0;
      key_snap_r <= '0;
      id_r       <= 1'b0;
    end else if (accept_s) begin
      data_r     <= grant_s ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
      key_snap_r <= key_r;
      id_r       <= grant_s;
    end
  end

  // WAIT timer: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      timer_r <= 8'd0;
    end else if (state_r == ISSUE) begin
      timer_r <= 8'd0;
    end else if (state_r == WAIT) begin
      timer_r <= timer_r + 8'd1;
    end
  end

  // Response payload: stage result on completion, zero with error on timeout.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else if (done_s) begin
      rsp_data_r <= stg_result;
      rsp_err_r  <= 1'b0;
    end else if (tmo_s) begin
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b1;
    end
  end

  // Round-robin history advances only when a response is consumed.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (release_s) begin
      last_r <= id_r;
    end
  end

  assign stg_start = (state_r == ISSUE);
  assign stg_data  = data_r;
  assign stg_key   = key_snap_r;
  assign rsp_valid = (state_r == RESP);
  assign rsp_id    = id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = (state_r != IDLE);

endmodule
